uart_baud_gen: RTL and testbench
================================

Name: uart_baud_gen

Overview:
Parametrised, runtime-programmable baud generator for the UART TX/RX paths. It replaces free-running divided clocks with single-cycle enable strobes. A phase-accumulator (NCO) gives fractional division, so any baud rate is reachable from the 50 MHz system clock. It provides an oversampled RX tick, a re-alignable mid-bit RX sample strobe, and a TX bit tick, and it sits between the register interface and the UART TX/RX state machines.

Parameters:
CLK_HZ  50000000  system clock frequency in Hz (documentation and DEFAULT_INC derivation only)
BAUD  115200  reset-time baud rate
OVERSAMPLE  16  RX ticks per bit; power of two, minimum 4
ACC_W  24  phase accumulator and increment width
DEFAULT_INC  618475  reset increment = round(BAUD*OVERSAMPLE*2^ACC_W/CLK_HZ)

Ports:
clk_50m  in  1  system clock; all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  generator enable; low freezes all state
cfg_wr  in  1  one-cycle strobe; loads cfg_inc
cfg_inc  in  ACC_W  new phase increment
rx_restart  in  1  one-cycle strobe from RX start-bit edge detector; re-aligns RX bit phase
rx_tick  out  1  one-cycle strobe, OVERSAMPLE per bit period
rx_sample  out  1  one-cycle strobe at RX mid-bit
tx_tick  out  1  one-cycle strobe, one per bit period
inc_cur  out  ACC_W  currently active increment (readback)

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc=0, inc_reg=DEFAULT_INC, rx_sub=0, tx_sub=0.
  - rx_tick=0, rx_sample=0, tx_tick=0, inc_cur=DEFAULT_INC.
  - Reset asserted mid-operation aborts immediately, with no partial strobe.
- Registers: acc[ACC_W], inc_reg[ACC_W], rx_sub and tx_sub each log2(OVERSAMPLE) bits. All outputs are registered.
- Priority each cycle: cfg_wr > rx_restart > normal advance.
- cfg_wr=1 (regardless of en):
  - inc_reg<=cfg_inc; acc, rx_sub and tx_sub cleared.
  - All strobes 0 next cycle.
  - Any rx_restart in the same cycle is subsumed.
- en=0, no cfg_wr: all state holds and all strobes are 0 next cycle. rx_restart is still honoured.
- Normal advance (en=1):
  - sum = {1'b0,acc} + inc_reg, computed ACC_W+1 bits wide; acc <= sum[ACC_W-1:0].
  - rx_tick <= sum[ACC_W] (carry). At most one tick per cycle because inc_reg < 2^ACC_W.
- inc_reg=0: no ticks ever. This is legal and is the idle/disabled rate.
- On each carry:
  - rx_sub <= rx_sub+1, wrapping modulo OVERSAMPLE.
  - rx_sample <= 1 iff the pre-increment rx_sub == OVERSAMPLE/2-1.
  - tx_sub <= tx_sub+1, wrapping modulo OVERSAMPLE.
  - tx_tick <= 1 iff the pre-increment tx_sub == OVERSAMPLE-1.
- rx_restart=1 (no cfg_wr):
  - rx_sub <= 0; rx_sample <= 0 that cycle.
  - acc, tx_sub and tx_tick advance normally.
  - rx_tick still asserts if a carry occurs.
  - Result: the first rx_sample falls on the OVERSAMPLE/2-th carry after restart.
- TX and RX phases are independent: rx_restart never perturbs tx_tick timing.
- Latency: a strobe is high the cycle after the clock edge whose accumulation carried.
- Strobes are exactly one cycle wide. rx_sample and tx_tick always coincide with rx_tick.
- Rate: average rx_tick frequency = CLK_HZ*inc_reg/2^ACC_W. Tick spacing jitter is at most 1 clock.
- inc_cur = inc_reg at all times.

Test Plan:
- Reset, en=1, defaults, run 1,000,000 cycles -> exactly 36863 rx_tick, 2303 tx_tick, 2304 rx_sample. Every rx_tick spacing is 27 or 28 cycles.
- cfg_wr with cfg_inc=4194304 (2^22), en=1 -> rx_tick every 4 cycles, first on the 4th edge after load. tx_tick every 64 cycles. rx_sample on the 8th rx_tick after load, then every 64 cycles. inc_cur=4194304.
- inc=2^22, pulse rx_restart mid-bit (tx_sub=5) -> next rx_sample exactly 32 cycles after the restart edge. tx_tick period stays 64, unshifted.
- rx_restart in the same cycle as a carry -> rx_tick=1, rx_sample=0, rx_sub=0. cfg_wr together with rx_restart -> load wins, all counters 0.
- Drop en for 100 cycles mid-bit -> no strobes during the gap; acc and counters resume from held values, and the tick spacing afterwards is unchanged. cfg_wr while en=0 still updates inc_cur.
- Assert rst_n low asynchronously between clock edges while strobes are active -> outputs 0 and inc_cur=DEFAULT_INC immediately. Load cfg_inc=0 -> no strobes for 10,000 cycles.

Source files
------------

// File: rtl/uart_baud_gen.sv
// Fractional-N baud generator: a phase accumulator emits an oversampled RX tick,
// a re-alignable mid-bit RX sample strobe and a TX bit tick, all as clock enables.
`timescale 1ns/1ps

module uart_baud_gen #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned DEFAULT_INC = 618475
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             rx_restart,
    output logic             rx_tick,
    output logic             rx_sample,
    output logic             tx_tick,
    output logic [ACC_W-1:0] inc_cur
);

    localparam int unsigned      SUB_W    = $clog2(OVERSAMPLE);
    localparam logic [ACC_W-1:0] RST_INC  = ACC_W'(DEFAULT_INC);
    localparam logic [SUB_W-1:0] RX_MID   = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);

    // Nominal reset increment, rounded to nearest; a mismatch means the
    // parameter set was edited inconsistently.
    localparam longint unsigned NOM_INC =
        (longint'(BAUD) * longint'(OVERSAMPLE) * (longint'(1) << ACC_W)
         + longint'(CLK_HZ) / 2) / longint'(CLK_HZ);

    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("uart_baud_gen: OVERSAMPLE must be a power of two >= 4");
    end
    if (NOM_INC != longint'(DEFAULT_INC)) begin : g_bad_default_inc
        $error("uart_baud_gen: DEFAULT_INC does not match CLK_HZ/BAUD/OVERSAMPLE");
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_reg;
    logic [SUB_W-1:0] rx_sub;
    logic [SUB_W-1:0] tx_sub;

    logic [ACC_W:0]   sum;
    logic             carry;

    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] inc_nxt;
    logic [SUB_W-1:0] rx_sub_nxt;
    logic [SUB_W-1:0] tx_sub_nxt;
    logic             rx_tick_nxt;
    logic             rx_sample_nxt;
    logic             tx_tick_nxt;

    always_comb begin
        sum   = {1'b0, acc} + {1'b0, inc_reg};
        carry = sum[ACC_W];
    end

    // Strobe semantics: every output strobe is a single-cycle, registered
    // enable with no back-pressure; consumers must act on the cycle it is high.
    // Precedence per cycle: cfg_wr, then rx_restart, then normal advance.
    always_comb begin
        inc_nxt       = inc_reg;
        acc_nxt       = acc;
        rx_sub_nxt    = rx_sub;
        tx_sub_nxt    = tx_sub;
        rx_tick_nxt   = 1'b0;
        rx_sample_nxt = 1'b0;
        tx_tick_nxt   = 1'b0;

        if (cfg_wr) begin
            inc_nxt    = cfg_inc;
            acc_nxt    = '0;
            rx_sub_nxt = '0;
            tx_sub_nxt = '0;
        end else begin
            if (en) begin
                acc_nxt     = sum[ACC_W-1:0];
                rx_tick_nxt = carry;
                if (carry) begin
                    tx_sub_nxt  = tx_sub + SUB_ONE;
                    tx_tick_nxt = (tx_sub == SUB_LAST);
                end
            end
            // Restart re-phases only the RX sample counter, even while disabled.
            if (rx_restart) begin
                rx_sub_nxt = '0;
            end else if (en && carry) begin
                rx_sub_nxt    = rx_sub + SUB_ONE;
                rx_sample_nxt = (rx_sub == RX_MID);
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            inc_reg   <= RST_INC;
            rx_sub    <= '0;
            tx_sub    <= '0;
            rx_tick   <= 1'b0;
            rx_sample <= 1'b0;
            tx_tick   <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            inc_reg   <= inc_nxt;
            rx_sub    <= rx_sub_nxt;
            tx_sub    <= tx_sub_nxt;
            rx_tick   <= rx_tick_nxt;
            rx_sample <= rx_sample_nxt;
            tx_tick   <= tx_tick_nxt;
        end
    end

    assign inc_cur = inc_reg;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: expected strobe events are queued by the
// stimulus thread and matched by an independent negedge monitor.
`timescale 1ns/1ps

module tb_uart_baud_gen;

    localparam int unsigned ACC_W   = 24;
    localparam int unsigned DEF_INC = 618475;
    localparam int unsigned INC_Q   = 4194304;
    localparam int unsigned EV_W    = 35;

    logic             clk_50m = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_wr;
    logic [ACC_W-1:0] cfg_inc;
    logic             rx_restart;
    logic             rx_tick;
    logic             rx_sample;
    logic             tx_tick;
    logic [ACC_W-1:0] inc_cur;

    uart_baud_gen dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .cfg_inc    (cfg_inc),
        .rx_restart (rx_restart),
        .rx_tick    (rx_tick),
        .rx_sample  (rx_sample),
        .tx_tick    (tx_tick),
        .inc_cur    (inc_cur)
    );

    // clock / reset / cycle stamp
    always #10 clk_50m = ~clk_50m;

    int unsigned cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          mon_en = 1'b0;

    // scoreboard: {cycle, rx_tick, rx_sample, tx_tick}
    logic [EV_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int unsigned c, input bit r, input bit s, input bit t);
        exp_q.push_back({c, r, s, t});
    endtask

    logic [EV_W-1:0] mon_got;
    logic [EV_W-1:0] mon_exp;
    always @(negedge clk_50m) begin
        if (mon_en && (rx_tick || rx_sample || tx_tick)) begin
            mon_got = {cyc, rx_tick, rx_sample, tx_tick};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: cycle %0d got rx_tick=%b rx_sample=%b tx_tick=%b required no strobe",
                         cyc, rx_tick, rx_sample, tx_tick);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL strobe_event: got cycle %0d flags %b required cycle %0d flags %b",
                             mon_got[EV_W-1:3], mon_got[2:0], mon_exp[EV_W-1:3], mon_exp[2:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic wait_cyc(input int unsigned target);
        int unsigned guard = 0;
        while (cyc != target && guard < 50000) begin
            @(negedge clk_50m);
            guard++;
        end
        if (cyc != target) check("wait_timeout", cyc, target);
    endtask

    task automatic load(input logic [ACC_W-1:0] v, input bit with_restart, output int unsigned l);
        @(negedge clk_50m);
        cfg_inc    = v;
        cfg_wr     = 1'b1;
        rx_restart = with_restart;
        l          = cyc + 1;
        @(negedge clk_50m);
        cfg_wr     = 1'b0;
        rx_restart = 1'b0;
    endtask

    task automatic pulse_restart_at(input int unsigned edge_c);
        wait_cyc(edge_c - 1);
        rx_restart = 1'b1;
        @(negedge clk_50m);
        rx_restart = 1'b0;
    endtask

    task automatic drain(input int unsigned end_c, input string name);
        wait_cyc(end_c);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    int unsigned l1, l2, l3, l4, l5;
    int unsigned n_rx, n_s, n_tx, first_t, last_t, bad_sp, orphan, quiet;
    bit          seen;

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        cfg_wr     = 1'b0;
        rx_restart = 1'b0;
        cfg_inc    = '0;
        repeat (3) @(negedge clk_50m);

        check("rst_rx_tick",   rx_tick,   0);
        check("rst_rx_sample", rx_sample, 0);
        check("rst_tx_tick",   tx_tick,   0);
        check("rst_inc_cur",   inc_cur,   DEF_INC);

        // default rate over 20000 edges: floor(20000*618475/2^24) = 737 carries
        rst_n = 1'b1;
        n_rx = 0; n_s = 0; n_tx = 0; first_t = 0; last_t = 0; bad_sp = 0; orphan = 0;
        for (int i = 1; i <= 20000; i++) begin
            @(negedge clk_50m);
            if (rx_tick) begin
                n_rx++;
                if (n_rx == 1) first_t = i;
                else if ((i - last_t) != 27 && (i - last_t) != 28) bad_sp++;
                last_t = i;
            end
            if (rx_sample) n_s++;
            if (tx_tick) n_tx++;
            if ((rx_sample || tx_tick) && !rx_tick) orphan++;
        end
        check("def_first_tick", first_t, 28);
        check("def_rx_ticks",   n_rx,    737);
        check("def_tx_ticks",   n_tx,    46);
        check("def_rx_samples", n_s,     46);
        check("def_bad_spacing", bad_sp, 0);
        check("def_orphan_strobe", orphan, 0);

        // inc = 2^22: tick every 4 edges; restarts at tick 5 and tick 29
        load(INC_Q[ACC_W-1:0], 1'b0, l1);
        check("load_inc_cur", inc_cur, INC_Q);
        check("load_strobes", {rx_tick, rx_sample, tx_tick}, 0);
        for (int m = 1; m <= 40; m++)
            push_ev(l1 + 4 * m, 1'b1, (m == 13) || (m == 37), (m % 16) == 0);
        mon_en = 1'b1;
        pulse_restart_at(l1 + 20);
        check("rst_carry_rx_tick",   rx_tick,    1);
        check("rst_carry_rx_sample", rx_sample,  0);
        check("rst_carry_rx_sub",    dut.rx_sub, 0);
        check("rst_carry_tx_sub",    dut.tx_sub, 5);
        pulse_restart_at(l1 + 116);
        check("rst_mid_rx_tick",   rx_tick,    1);
        check("rst_mid_rx_sample", rx_sample,  0);
        check("rst_mid_rx_sub",    dut.rx_sub, 0);
        drain(l1 + 163, "restart_run_missing");
        mon_en = 1'b0;

        // load together with restart, then a 100-cycle enable gap
        load(INC_Q[ACC_W-1:0], 1'b1, l2);
        check("load_rst_acc",     dut.acc,    0);
        check("load_rst_rx_sub",  dut.rx_sub, 0);
        check("load_rst_tx_sub",  dut.tx_sub, 0);
        check("load_rst_strobes", {rx_tick, rx_sample, tx_tick}, 0);
        for (int m = 1; m <= 32; m++)
            push_ev((m <= 10) ? (l2 + 4 * m) : (l2 + 100 + 4 * m), 1'b1,
                    (m == 8) || (m == 24), (m == 16) || (m == 32));
        mon_en = 1'b1;
        wait_cyc(l2 + 41);
        en = 1'b0;
        wait_cyc(l2 + 90);
        check("gap_acc",    dut.acc,    INC_Q);
        check("gap_tx_sub", dut.tx_sub, 10);
        check("gap_rx_sub", dut.rx_sub, 10);
        wait_cyc(l2 + 141);
        en = 1'b1;
        drain(l2 + 230, "gap_run_missing");
        mon_en = 1'b0;

        // configuration write while disabled
        @(negedge clk_50m);
        en = 1'b0;
        load(24'd1234, 1'b0, l3);
        check("dis_load_inc_cur", inc_cur, 1234);
        check("dis_load_acc",     dut.acc, 0);
        en = 1'b1;

        // asynchronous reset between edges while strobes are active
        load(24'hFFFFFF, 1'b0, l4);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_50m);
            if (rx_tick) seen = 1'b1;
        end
        check("fast_tick_seen", seen, 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_strobes", {rx_tick, rx_sample, tx_tick}, 0);
        check("arst_inc_cur", inc_cur, DEF_INC);
        check("arst_acc",     dut.acc, 0);
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;

        // zero increment: silent
        load('0, 1'b0, l5);
        mon_en = 1'b1;
        quiet = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk_50m);
            if (rx_tick || rx_sample || tx_tick) quiet++;
        end
        mon_en = 1'b0;
        check("zero_inc_strobes", quiet, 0);
        check("zero_inc_cur", inc_cur, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
